gpc_stream: RTL and testbench
=============================

GPC_STREAM -- requirements
Module: gpc_stream

Interface
REQ-001 SHALL have parameter H0, default 1: number of weight-1 input bits; range 1..15.
REQ-002 SHALL have parameter H1, default 5: number of weight-2 input bits; range 1..15.
REQ-003 SHALL have parameter H2, default 1: number of weight-4 input bits; range 1..15.
REQ-004 SHALL have parameter ACC_W, default 8: accumulator width; must be >= DW.
REQ-005 SHALL define localparam DW = clog2(H0 + 2*H1 + 4*H2 + 1); the defaults give DW = 4.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port src0, input, H0 bits: the weight-1 column.
REQ-009 SHALL have port src1, input, H1 bits: the weight-2 column.
REQ-010 SHALL have port src2, input, H2 bits: the weight-4 column.
REQ-011 SHALL have port in_valid, input, 1 bit: the src buses carry a valid operand.
REQ-012 SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-013 SHALL have port dst, output, DW bits: the compressed sum.
REQ-014 SHALL have port out_valid, output, 1 bit: dst is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts dst.
REQ-016 SHALL have port acc_clr, input, 1 bit: clears the accumulator (present only with GPC_STREAM_ACC_EN).
REQ-017 SHALL have port acc, output, ACC_W bits: the running sum of delivered results (GPC_STREAM_ACC_EN only).
REQ-018 SHALL have port acc_ovf, output, 1 bit: sticky accumulator overflow flag (GPC_STREAM_ACC_EN only).

Function
REQ-019 SHALL compute dst = popcount(src0) + 2*popcount(src1) + 4*popcount(src2), exact and never truncated within DW bits.
REQ-020 SHALL accept an operand in a cycle where in_valid && in_ready, and deliver a result in a cycle where out_valid && out_ready.
REQ-021 SHALL use a two-stage pipeline:
- S1 registers the three per-column popcounts plus v1.
- S2 registers the weighted sum plus v2.
REQ-022 SHALL make latency exactly 2 cycles from the accept edge to out_valid=1 when there is no backpressure.
REQ-023 SHALL load S2 (load2) when !v2 || out_ready, and load S1 (load1) when !v1 || load2.
REQ-024 SHALL drive in_ready = !v1 || load2, so bubbles collapse and in_ready may depend combinationally on out_ready.
REQ-025 SHALL hold dst and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL sustain throughput of 1 result per cycle with out_ready held at 1.
REQ-027 SHALL never drop or duplicate an operand, and SHALL deliver results in acceptance order.
REQ-028 SHALL ignore src buses in cycles where in_valid is 0.

Reset
REQ-029 SHALL, while rst_n=0, clear v1, v2, dst, acc and acc_ovf to 0 immediately, without waiting for clk.
REQ-030 SHALL discard any in-flight operands when reset is asserted mid-stream; after release, in_ready=1 and out_valid=0.
REQ-031 SHALL give S1 popcount registers a reset value of 0.

Configuration
REQ-032 SHALL provide the accumulator only when macro GPC_STREAM_ACC_EN is defined; without it, acc, acc_clr, acc_ovf and all their logic are absent.
REQ-033 SHALL, with the accumulator compiled in, update it on each delivery as acc <= acc + dst, modulo 2^ACC_W.
REQ-034 SHALL set acc_ovf when an update produces a carry out of ACC_W bits; acc_ovf then holds until acc_clr or reset.
REQ-035 SHALL, on acc_clr without a delivery, set acc <= 0 and acc_ovf <= 0.
REQ-036 SHALL, on acc_clr in the same cycle as a delivery, set acc <= dst and acc_ovf <= 0.
REQ-037 SHALL keep pipeline behaviour (REQ-019..REQ-028) identical with and without GPC_STREAM_ACC_EN.

Structure
REQ-038 SHALL place clog2 and the function computing DW from (H0,H1,H2) in shared package gpc_pkg.
REQ-039 SHALL instantiate sub-module gpc_popcount (parameter N, output clog2(N+1) bits) once per column.

Verification
REQ-040 Defaults, out_ready=1: stream all 128 values of {src2,src1,src0} back-to-back -> 128 results in order, each equal to the weighted sum (e.g. 7'h7f -> 15), each 2 cycles after its accept.
REQ-041 Apply out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 further accepts; dst held; no loss or reorder after release.
REQ-042 Input src1=5'b11111 at H1=5 -> dst=10; at H0=H1=H2=15 with all inputs 1 -> dst=105, DW=7.
REQ-043 Assert rst_n=0 with 2 operands in flight -> out_valid=0 at once; no stale result appears after release.
REQ-044 With GPC_STREAM_ACC_EN, ACC_W=8: deliver 17 results of 15 -> acc=255, acc_ovf=0; an 18th -> acc=14, acc_ovf=1.
REQ-045 With GPC_STREAM_ACC_EN: acc_clr together with delivery of 9 -> acc=9, acc_ovf=0.

Source files
------------

// File: rtl/gpc_pkg.sv
// gpc_pkg: shared helpers for the generalised parallel counter stream.
// Holds clog2 and the result-width function used by gpc_stream.
package gpc_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int gpc_dw(input int h0, input int h1, input int h2);
        return clog2(h0 + 2 * h1 + 4 * h2 + 1);
    endfunction

endpackage

// File: rtl/gpc_popcount.sv
// gpc_popcount: combinational population count of an N-bit column.
// Output is wide enough to hold N itself.
module gpc_popcount
    import gpc_pkg::*;
#(
    parameter int N = 1,
    localparam int W = clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] cnt
);

    // sum the ones of the column
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(bits[i]);
        end
    end

endmodule

// File: rtl/gpc_stream.sv
// gpc_stream: two-stage (1,5,1)-style weighted popcount with valid/ready.
// Optional running accumulator enabled by macro GPC_STREAM_ACC_EN.
module gpc_stream
    import gpc_pkg::*;
#(
    parameter int H0 = 1,
    parameter int H1 = 5,
    parameter int H2 = 1,
    parameter int ACC_W = 8,
    localparam int DW = gpc_dw(H0, H1, H2)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef GPC_STREAM_ACC_EN
    input  logic          acc_clr,
    output logic [ACC_W-1:0] acc,
    output logic          acc_ovf,
`endif
    input  logic [H0-1:0] src0,
    input  logic [H1-1:0] src1,
    input  logic [H2-1:0] src2,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dst,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int W0 = clog2(H0 + 1);
    localparam int W1 = clog2(H1 + 1);
    localparam int W2 = clog2(H2 + 1);

    logic [W0-1:0] pc0, c0;
    logic [W1-1:0] pc1, c1;
    logic [W2-1:0] pc2, c2;
    logic          v1, v2;
    logic          load1, load2;
    logic [DW-1:0] wsum;

    gpc_popcount #(.N(H0)) u_pc0 (.bits(src0), .cnt(pc0));
    gpc_popcount #(.N(H1)) u_pc1 (.bits(src1), .cnt(pc1));
    gpc_popcount #(.N(H2)) u_pc2 (.bits(src2), .cnt(pc2));

    assign load2    = !v2 || out_ready;
    assign load1    = !v1 || load2;
    assign in_ready = load1;

    // weight the column counts; DW always covers the maximum sum
    always_comb begin
        wsum = DW'(c0) + (DW'(c1) << 1) + (DW'(c2) << 2);
    end

    // stage 1: per-column popcounts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            c0 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                c0 <= pc0;
                c1 <= pc1;
                c2 <= pc2;
            end
        end
    end

    // stage 2: weighted sum, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            dst <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) dst <= wsum;
        end
    end

    assign out_valid = v2;

`ifdef GPC_STREAM_ACC_EN
    logic           deliver;
    logic [ACC_W:0] acc_sum;

    assign deliver = v2 && out_ready;
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(dst);

    // running sum of delivered results with sticky carry-out flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (acc_clr) begin
            acc     <= deliver ? ACC_W'(dst) : '0;
            acc_ovf <= 1'b0;
        end else if (deliver) begin
            acc     <= acc_sum[ACC_W-1:0];
            acc_ovf <= acc_ovf | acc_sum[ACC_W];
        end
    end
`endif

endmodule

// File: tb/tb_gpc_stream.sv
// tb_gpc_stream: table vectors, full sweep and corner sequences.
// Results are checked through an expected-value scoreboard queue.
module tb_gpc_stream;

    typedef struct {
        logic [6:0] v;
        logic [3:0] e;
    } vec_t;

    typedef struct {
        logic [3:0] e;
        int         cyc;
        bit         lat;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] src0 = '0;
    logic [4:0] src1 = '0;
    logic [0:0] src2 = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dst;
    logic       out_valid;
    logic       out_ready = 1'b1;

    logic [14:0] b_src = '1;
    logic        b_in_ready;
    logic [6:0]  b_dst;
    logic        b_out_valid;

`ifdef GPC_STREAM_ACC_EN
    logic       acc_clr = 1'b0;
    logic [7:0] acc;
    logic       acc_ovf;
    logic       b_acc_clr = 1'b0;
    logic [7:0] b_acc;
    logic       b_acc_ovf;
`endif

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    bit  lat_on = 1'b0;
    bit  held_v = 1'b0;
    logic [3:0] held_d = '0;
    sb_t q[$];
    vec_t vt[10];

    gpc_stream dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef GPC_STREAM_ACC_EN
        .acc_clr(acc_clr),
        .acc(acc),
        .acc_ovf(acc_ovf),
`endif
        .src0(src0),
        .src1(src1),
        .src2(src2),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dst(dst),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    gpc_stream #(.H0(15), .H1(15), .H2(15), .ACC_W(8)) u_big (
        .clk(clk),
        .rst_n(rst_n),
`ifdef GPC_STREAM_ACC_EN
        .acc_clr(b_acc_clr),
        .acc(b_acc),
        .acc_ovf(b_acc_ovf),
`endif
        .src0(b_src),
        .src1(b_src),
        .src2(b_src),
        .in_valid(1'b1),
        .in_ready(b_in_ready),
        .dst(b_dst),
        .out_valid(b_out_valid),
        .out_ready(1'b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    function automatic logic [3:0] model(input logic [6:0] v);
        return 4'(v[0]) + 4'(2 * $countones(v[5:1])) + 4'(4 * v[6]);
    endfunction

    // scoreboard: pop on delivery, push on accept, check held output
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_dst", int'(dst), int'(held_d));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", int'(dst), -1);
                end else begin
                    sb_t s;
                    s = q.pop_front();
                    chk("dst", int'(dst), int'(s.e));
                    if (s.lat) chk("latency", cyc - s.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                sb_t s;
                s.e = model({src2, src1, src0});
                s.cyc = cyc;
                s.lat = lat_on;
                q.push_back(s);
            end
            held_v = out_valid && !out_ready;
            held_d = dst;
        end
    end

    task automatic send(input logic [6:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        {src2, src1, src0} = v;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {src2, src1, src0} = 7'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{7'h00, 4'd0};
        vt[1] = '{7'h7f, 4'd15};
        vt[2] = '{7'b0111110, 4'd10};
        vt[3] = '{7'h01, 4'd1};
        vt[4] = '{7'h40, 4'd4};
        vt[5] = '{7'b0000010, 4'd2};
        vt[6] = '{7'b1000001, 4'd5};
        vt[7] = '{7'b0101010, 4'd6};
        vt[8] = '{7'b1010101, 4'd9};
        vt[9] = '{7'b0111111, 4'd11};

        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dst", int'(dst), 0);
        chk("rst_in_ready", int'(in_ready), 1);
`ifdef GPC_STREAM_ACC_EN
        chk("rst_acc", int'(acc), 0);
        chk("rst_acc_ovf", int'(acc_ovf), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        chk("big_valid", int'(b_out_valid), 1);
        chk("big_dst", int'(b_dst), 105);
        @(posedge clk);
        #1;

        lat_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q.push_back('{vt[i].e, 0, 1'b0});
            void'(q.pop_back());
            send(vt[i].v);
        end
        drain();

        for (int i = 0; i < 128; i++) send(7'(i));
        drain();
        lat_on = 1'b0;

        fork
            begin
                for (int i = 0; i < 20; i++) send(7'(i * 37));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        fork
            begin
                send(7'h7f);
                send(7'h2a);
                send(7'h55);
                send(7'h3e);
            end
            begin
                int na;
                na = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (in_valid && in_ready) na++;
                end
                chk("stall_accepts", na, 2);
                chk("stall_in_ready", int'(in_ready), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(7'h7f);
        send(7'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_out", int'(out_valid), 0);

`ifdef GPC_STREAM_ACC_EN
        for (int i = 0; i < 17; i++) send(7'h7f);
        drain();
        chk("acc_255", int'(acc), 255);
        chk("acc_ovf_0", int'(acc_ovf), 0);
        send(7'h7f);
        drain();
        chk("acc_wrap", int'(acc), 14);
        chk("acc_ovf_1", int'(acc_ovf), 1);
        out_ready = 1'b0;
        send(7'b1000111);
        repeat (2) @(posedge clk);
        #1;
        acc_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        chk("acc_clr_dlv", int'(acc), 9);
        chk("acc_clr_ovf", int'(acc_ovf), 0);
        drain();
`endif

        send(7'b0111110);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
